io_wait_req: RTL and testbench

Input-wait stall requester for the CPU's memory-mapped input port. It sits on the IO read path and drives `stall_req_io` into the pipeline stall controller. When the core reads the user-input address, it holds the pipeline stalled until the operator presses the enter button, samples the switches, and releases the stall for exactly one cycle with the captured value. It also exports a debounced single-cycle enter pulse, which the stall controller uses for its start-up release.

---
 rtl/io_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 69 ++++++
 rtl/io_wait_req.sv | 104 ++++++++++
 tb/tb_io_wait_req.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared types and constants for the memory-mapped input port
//
// Contents:
//   io_state_e     : wait-request FSM state encoding (2-bit)
//   IO_SW_ADDR     : byte address of the user-input (switch) port
//   IO_LED_ADDR    : byte address of the LED output port
//   is_sw_addr()   : address-decoder helper that produces io_rd_req
package io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_PRESS   = 2'd2,
    ST_DONE    = 2'd3
  } io_state_e;

  localparam logic [31:0] IO_SW_ADDR  = 32'hFFFF_FC70;
  localparam logic [31:0] IO_LED_ADDR = 32'hFFFF_FC60;

  // Word-aligned match; the decoder ANDs this with the load strobe.
  function automatic logic is_sw_addr(input logic [31:0] addr);
    return (addr[31:2] == IO_SW_ADDR[31:2]);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchroniser plus counter debouncer for one push button
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   btn_raw    in   raw, bouncing, asynchronous button level
//   level      out  debounced button level
//   rise_pulse out  one-cycle pulse on each debounced rising edge
//
// Latency from a stable raw edge to the level change (and pulse) is
// 2 synchroniser cycles + DEBOUNCE_CYCLES + 1.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic             pulse_q;
  logic             pulse_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The counter only runs while the synchronised input disagrees with the
  // debounced level; any agreement (a bounce back) restarts the wait.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    pulse_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level      = level_q;
  assign rise_pulse = pulse_q;

endmodule

// File: rtl/io_wait_req.sv
// rtl/io_wait_req.sv - stalls an input-port load until the operator presses enter
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous active-high reset
//   enter_raw      in   raw enter button (asynchronous, bouncing)
//   sw             in   raw switches, SW_WIDTH bits
//   io_rd_req      in   core is loading from the input address
//   stall_req_io   out  pipeline stall request (combinational)
//   io_rdata       out  last captured switch value, zero-extended to 32 bits
//   io_rdata_valid out  high for the single cycle the load consumes io_rdata
//   enter_pulse    out  one-cycle pulse on each debounced press
module io_wait_req
  import io_pkg::*;
#(
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enter_raw,
  input  logic [SW_WIDTH-1:0] sw,
  input  logic                io_rd_req,
  output logic                stall_req_io,
  output logic [31:0]         io_rdata,
  output logic                io_rdata_valid,
  output logic                enter_pulse
);

  logic      enter_level;
  logic      enter_rise;
  logic      capture;
  io_state_e state_q;
  io_state_e state_d;
  logic [31:0] rdata_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_enter_db (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (enter_raw),
    .level     (enter_level),
    .rise_pulse(enter_rise)
  );

  // A flush (io_rd_req dropping) takes priority over a press so that a
  // cancelled load never updates the data register.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (io_rd_req) begin
          // A button still held from an earlier read must be released first.
          state_d = enter_level ? ST_RELEASE : ST_PRESS;
        end
      end
      ST_RELEASE: begin
        if (!io_rd_req) begin
          state_d = ST_IDLE;
        end else if (!enter_level) begin
          state_d = ST_PRESS;
        end
      end
      ST_PRESS: begin
        if (!io_rd_req) begin
          state_d = ST_IDLE;
        end else if (enter_rise) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        rdata_q <= 32'(sw);
      end
    end
  end

  // Combinational so the stall lands in the same cycle as the request; gated
  // by rst so a reset mid-wait drops it without waiting for io_rd_req to fall.
  assign stall_req_io   = ~rst & (((state_q == ST_IDLE) & io_rd_req) |
                                  (state_q == ST_RELEASE) |
                                  (state_q == ST_PRESS));
  assign io_rdata_valid = (state_q == ST_DONE);
  assign io_rdata       = rdata_q;
  assign enter_pulse    = enter_rise;

endmodule

// File: tb/tb_io_wait_req.sv
// tb/tb_io_wait_req.sv - directed scoreboard bench for io_wait_req
module tb_io_wait_req;

  logic        clk;
  logic        rst;
  logic        enter_raw;
  logic [15:0] sw;
  logic        io_rd_req;
  logic        stall_req_io;
  logic [31:0] io_rdata;
  logic        io_rdata_valid;
  logic        enter_pulse;

  int          vectors;
  int          miscompares;
  int          pulse_cnt;
  int          pulse_base;
  logic [31:0] sb[$];
  logic [31:0] exp_v;

  io_wait_req #(
    .SW_WIDTH       (16),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enter_raw     (enter_raw),
    .sw            (sw),
    .io_rd_req     (io_rd_req),
    .stall_req_io  (stall_req_io),
    .io_rdata      (io_rdata),
    .io_rdata_valid(io_rdata_valid),
    .enter_pulse   (enter_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!io_rdata_valid && n < 20) begin
      tick(1);
      n++;
    end
    chk(tag, {31'd0, io_rdata_valid}, 32'd1);
  endtask

  // Scoreboard consumer: every valid cycle must match the oldest pushed value.
  always @(negedge clk) begin
    if (enter_pulse) pulse_cnt++;
    if (io_rdata_valid) begin
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_valid observed=%h expected=none", io_rdata);
      end
      if (sb.size() != 0) begin
        exp_v = sb.pop_front();
        vectors++;
        assert (io_rdata === exp_v) else begin
          miscompares++;
          $error("FAIL sb_rdata observed=%h expected=%h", io_rdata, exp_v);
        end
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    pulse_cnt   = 0;
    rst       = 1'b1;
    enter_raw = 1'b0;
    sw        = 16'h0000;
    io_rd_req = 1'b0;
    tick(2);
    chk("rst_stall", {31'd0, stall_req_io}, 32'd0);
    chk("rst_rdata", io_rdata, 32'd0);
    chk("rst_valid", {31'd0, io_rdata_valid}, 32'd0);
    chk("rst_pulse", {31'd0, enter_pulse}, 32'd0);
    rst = 1'b0;
    tick(1);

    // Clean press: pulse exactly 7 edges after the raw edge.
    sw = 16'hA5A5;
    io_rd_req = 1'b1;
    #1;
    chk("t1_stall_same_cycle", {31'd0, stall_req_io}, 32'd1);
    tick(1);
    sb.push_back(32'h0000A5A5);
    enter_raw = 1'b1;
    tick(6);
    chk("t1_no_pulse_at_6", {31'd0, enter_pulse}, 32'd0);
    tick(1);
    chk("t1_pulse_at_7", {31'd0, enter_pulse}, 32'd1);
    chk("t1_stall_in_press", {31'd0, stall_req_io}, 32'd1);
    tick(1);
    chk("t1_valid", {31'd0, io_rdata_valid}, 32'd1);
    chk("t1_rdata", io_rdata, 32'h0000A5A5);
    chk("t1_stall_done", {31'd0, stall_req_io}, 32'd0);
    chk("t1_pulse_single", {31'd0, enter_pulse}, 32'd0);
    io_rd_req = 1'b0;
    tick(1);
    chk("t1_valid_one_cycle", {31'd0, io_rdata_valid}, 32'd0);
    tick(1);
    enter_raw = 1'b0;
    tick(8);

    // Bounce rejection.
    sw = 16'h1234;
    io_rd_req = 1'b1;
    tick(1);
    pulse_base = pulse_cnt;
    for (int i = 0; i < 10; i++) begin
      enter_raw = ~enter_raw;
      tick(2);
    end
    chk("t2_bounce_no_pulse", pulse_cnt, pulse_base);
    chk("t2_bounce_stall", {31'd0, stall_req_io}, 32'd1);
    sb.push_back(32'h00001234);
    enter_raw = 1'b1;
    wait_valid("t2_capture_timeout");
    chk("t2_one_pulse", pulse_cnt, pulse_base + 1);
    io_rd_req = 1'b0;
    tick(2);

    // Held button: must release and re-press.
    io_rd_req = 1'b1;
    pulse_base = pulse_cnt;
    tick(15);
    chk("t3_held_stall", {31'd0, stall_req_io}, 32'd1);
    chk("t3_held_no_valid", {31'd0, io_rdata_valid}, 32'd0);
    enter_raw = 1'b0;
    tick(8);
    chk("t3_release_stall", {31'd0, stall_req_io}, 32'd1);
    sw = 16'hBEEF;
    sb.push_back(32'h0000BEEF);
    enter_raw = 1'b1;
    wait_valid("t3_capture_timeout");
    chk("t3_pulse_count", pulse_cnt, pulse_base + 1);
    io_rd_req = 1'b0;
    tick(1);
    enter_raw = 1'b0;
    tick(8);

    // Flush abort in PRESS.
    io_rd_req = 1'b1;
    tick(2);
    sw = 16'hFFFF;
    io_rd_req = 1'b0;
    tick(1);
    chk("t4_flush_stall", {31'd0, stall_req_io}, 32'd0);
    chk("t4_flush_rdata", io_rdata, 32'h0000BEEF);
    chk("t4_flush_valid", {31'd0, io_rdata_valid}, 32'd0);
    tick(3);

    // Asynchronous reset between edges while waiting in PRESS.
    io_rd_req = 1'b1;
    tick(2);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_stall", {31'd0, stall_req_io}, 32'd0);
    chk("t5_rst_rdata", io_rdata, 32'd0);
    chk("t5_rst_valid", {31'd0, io_rdata_valid}, 32'd0);
    chk("t5_rst_pulse", {31'd0, enter_pulse}, 32'd0);
    #1;
    rst = 1'b0;
    io_rd_req = 1'b0;
    tick(2);

    // Back-to-back reads.
    sw = 16'h0055;
    io_rd_req = 1'b1;
    tick(1);
    sb.push_back(32'h00000055);
    enter_raw = 1'b1;
    wait_valid("t6_first_timeout");
    tick(1);
    chk("t6_restall", {31'd0, stall_req_io}, 32'd1);
    chk("t6_valid_low", {31'd0, io_rdata_valid}, 32'd0);
    enter_raw = 1'b0;
    tick(8);
    sw = 16'h0003;
    sb.push_back(32'h00000003);
    enter_raw = 1'b1;
    wait_valid("t6_second_timeout");
    chk("t6_second_rdata", io_rdata, 32'h00000003);
    io_rd_req = 1'b0;
    tick(2);
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
